// File: rtl/tof_pkg.sv
// Shared types and default sizing for the ToF frame ping-pong buffer.
//   N_SENSORS_DEF / N_ZONES_DEF / DATA_W_DEF : default geometry of the capture path
//   tof_beat_t   : one distance beat {sensor, zone, data} at default widths
//   fsm_state_e  : frame-control states (FILL collects beats, WAIT_SWAP holds a
//                  complete frame until the consumer releases the read bank)
package tof_pkg;

    localparam int N_SENSORS_DEF = 8;
    localparam int N_ZONES_DEF   = 64;
    localparam int DATA_W_DEF    = 16;
    localparam int SENSOR_W_DEF  = $clog2(N_SENSORS_DEF);
    localparam int ZONE_W_DEF    = $clog2(N_ZONES_DEF);

    typedef struct packed {
        logic [SENSOR_W_DEF-1:0] sensor;
        logic [ZONE_W_DEF-1:0]   zone;
        logic [DATA_W_DEF-1:0]   data;
    } tof_beat_t;

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/tof_pingpong_ram.sv
// Simple dual-port frame memory with a registered read port (maps onto block RAM).
//   clk      : clock
//   reset    : asynchronous active-high reset, clears only the read data register
//   wr_en    : write strobe
//   wr_addr  : write address {bank, sensor, zone}
//   wr_data  : write data
//   rd_addr  : read address {bank, sensor, zone}
//   rd_data  : read data, valid one cycle after rd_addr
module tof_pingpong_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Array has no reset so it stays inferable as BRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tof_frame_pingpong_buffer.sv
// Collects per-zone ToF distance beats into one bank of a ping-pong frame memory,
// tracks arrived zones in a bitmap, and publishes each complete frame through the
// other bank with a valid/ack handshake.
//   clk, reset  : clock, asynchronous active-high reset
//   in_valid/in_ready, in_sensor, in_zone, in_data : incoming distance beats
//   sensor_en   : sensors required for a frame, sampled at each frame start
//   frame_valid/frame_ack : read bank holds a complete frame / consumer done
//   frame_id    : number of published frames (wraps at 8 bits)
//   rd_addr/rd_data : {sensor, zone} read into the read bank, 1-cycle latency
//   drop_cnt    : beats discarded while both banks were busy (saturating)
module tof_frame_pingpong_buffer
    import tof_pkg::*;
#(
    parameter int N_SENSORS    = N_SENSORS_DEF,
    parameter int N_ZONES      = N_ZONES_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16,
    parameter int SENSOR_W     = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1,
    parameter int ZONE_W       = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SENSOR_W-1:0]        in_sensor,
    input  logic [ZONE_W-1:0]          in_zone,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [N_SENSORS-1:0]       sensor_en,
    output logic                       frame_valid,
    input  logic                       frame_ack,
    output logic [7:0]                 frame_id,
    input  logic [SENSOR_W+ZONE_W-1:0] rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int ADDR_W = 1 + SENSOR_W + ZONE_W;

    fsm_state_e                       state;
    logic                             wr_bank;
    logic                             load_en;
    logic                             done;
    logic [N_SENSORS-1:0]             en_q;
    logic [N_SENSORS-1:0]             en_eff;
    logic [N_SENSORS-1:0][N_ZONES-1:0] bitmap;
    logic                             accept;
    logic                             beat_ok;
    logic                             wr_en;
    logic                             all_hit;
    logic                             swap;

    // Right after reset en_q has not captured sensor_en yet, so the first cycle
    // of the frame uses sensor_en directly.
    assign en_eff  = load_en ? sensor_en : en_q;
    assign accept  = in_valid & in_ready;
    assign beat_ok = (int'(in_sensor) < N_SENSORS) && en_eff[in_sensor];
    assign wr_en   = accept && (state == FILL) && beat_ok;

    // A sensor that is not required counts as complete.
    always_comb begin
        all_hit = 1'b1;
        for (int s = 0; s < N_SENSORS; s++) begin
            if (en_eff[s] && !(&bitmap[s])) begin
                all_hit = 1'b0;
            end
        end
    end

    assign swap = ((state == FILL) && done && (!frame_valid || frame_ack)) ||
                  ((state == WAIT_SWAP) && frame_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            in_ready    <= 1'b1;
            frame_valid <= 1'b0;
            frame_id    <= '0;
            drop_cnt    <= '0;
            wr_bank     <= 1'b0;
            bitmap      <= '0;
            en_q        <= '0;
            load_en     <= 1'b1;
            done        <= 1'b0;
        end else begin
            load_en <= 1'b0;
            en_q    <= en_eff;
            if (swap) begin
                // done is cleared here too, otherwise its stale value would
                // trigger a second swap on the freshly cleared bitmap.
                wr_bank     <= ~wr_bank;
                bitmap      <= '0;
                en_q        <= sensor_en;
                done        <= 1'b0;
                frame_valid <= 1'b1;
                frame_id    <= frame_id + 8'd1;
                state       <= FILL;
                in_ready    <= 1'b1;
            end else begin
                if (wr_en) begin
                    bitmap[in_sensor][in_zone] <= 1'b1;
                end
                done <= all_hit && (|en_eff);
                if (state == FILL) begin
                    if (done) begin
                        // Read bank still owned by the consumer.
                        state    <= WAIT_SWAP;
                        in_ready <= (DROP_ON_FULL != 0);
                    end else if (frame_valid && frame_ack) begin
                        frame_valid <= 1'b0;
                    end
                end
            end
            if ((state == WAIT_SWAP) && accept && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    tof_pingpong_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, in_sensor, in_zone}),
        .wr_data (in_data),
        .rd_addr ({~wr_bank, rd_addr}),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_tof_frame_pingpong_buffer.sv
// Directed bench for tof_frame_pingpong_buffer: a back-pressure instance
// (DROP_ON_FULL=0) and a dropping instance (DROP_ON_FULL=1) share one stimulus.
module tb_tof_frame_pingpong_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_sensor;
    logic [5:0]  in_zone;
    logic [15:0] in_data;
    logic [7:0]  sensor_en;
    logic        frame_ack;
    logic [8:0]  rd_addr;

    logic        in_ready,    in_ready_d;
    logic        frame_valid, frame_valid_d;
    logic [7:0]  frame_id,    frame_id_d;
    logic [15:0] rd_data,     rd_data_d;
    logic [15:0] drop_cnt,    drop_cnt_d;

    int errors = 0;
    int checks = 0;

    logic [15:0] r0, rd;

    always #5 clk = ~clk;

    tof_frame_pingpong_buffer #(.DROP_ON_FULL(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sensor(in_sensor), .in_zone(in_zone), .in_data(in_data),
        .sensor_en(sensor_en), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_id(frame_id), .rd_addr(rd_addr), .rd_data(rd_data), .drop_cnt(drop_cnt)
    );

    tof_frame_pingpong_buffer #(.DROP_ON_FULL(1)) dut_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_d),
        .in_sensor(in_sensor), .in_zone(in_zone), .in_data(in_data),
        .sensor_en(sensor_en), .frame_valid(frame_valid_d), .frame_ack(frame_ack),
        .frame_id(frame_id_d), .rd_addr(rd_addr), .rd_data(rd_data_d), .drop_cnt(drop_cnt_d)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_beat(input int s, input int z, input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_sensor = 3'(s); in_zone = 6'(z); in_data = d;
    endtask

    task automatic end_beats();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] mask);
        for (int s = 0; s < 8; s++)
            for (int z = 0; z < 64; z++)
                send_beat(s, z, {8'(s), 8'(z)} ^ mask);
        end_beats();
    endtask

    task automatic read(input int s, input int z, output logic [15:0] v0, output logic [15:0] vd);
        @(negedge clk);
        rd_addr = {3'(s), 6'(z)};
        @(negedge clk);
        v0 = rd_data; vd = rd_data_d;
    endtask

    task automatic test_reset();
        sensor_en = 8'hFF;
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_frame_valid: got %b want 0", frame_valid); end
        checks++; if (frame_id !== 8'd0) begin errors++; $display("FAIL rst_frame_id: got %0d want 0", frame_id); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
        checks++; if (drop_cnt_d !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt_d); end
    endtask

    task automatic test_full_frame();
        for (int s = 0; s < 8; s++)
            for (int z = 0; z < 64; z++)
                send_beat(s, z, {8'(s), 8'(z)});
        end_beats();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL lat_e1: got %b want 0", frame_valid); end
        idle(1);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL lat_e2: got %b want 0", frame_valid); end
        idle(1);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", frame_valid); end
        checks++; if (frame_id !== 8'd1) begin errors++; $display("FAIL full_id: got %0d want 1", frame_id); end
        read(3, 5, r0, rd);
        checks++; if (r0 !== 16'h0305) begin errors++; $display("FAIL full_rd_3_5: got %h want 0305", r0); end
        read(7, 63, r0, rd);
        checks++; if (r0 !== 16'h073F) begin errors++; $display("FAIL full_rd_7_63: got %h want 073f", r0); end
    endtask

    task automatic test_back_to_back();
        send_frame(16'hFF00);
        idle(2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", in_ready); end
        checks++; if (in_ready_d !== 1'b1) begin errors++; $display("FAIL b2b_drop_ready: got %b want 1", in_ready_d); end
        checks++; if (frame_id !== 8'd1) begin errors++; $display("FAIL b2b_id_hold: got %0d want 1", frame_id); end
        read(3, 5, r0, rd);
        checks++; if (r0 !== 16'h0305) begin errors++; $display("FAIL b2b_rd_old: got %h want 0305", r0); end
        // Extra beats while both banks are busy.
        for (int i = 0; i < 10; i++) send_beat(3, 5, 16'hDEAD);
        end_beats();
        checks++; if (drop_cnt_d !== 16'd10) begin errors++; $display("FAIL drop_cnt: got %0d want 10", drop_cnt_d); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL stall_drop_cnt: got %0d want 0", drop_cnt); end
        read(3, 5, r0, rd);
        checks++; if (rd !== 16'h0305) begin errors++; $display("FAIL drop_rd_bank: got %h want 0305", rd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_pre_ack_ready: got %b want 0", in_ready); end
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ack_swap_valid: got %b want 1", frame_valid); end
        checks++; if (frame_id !== 8'd2) begin errors++; $display("FAIL ack_swap_id: got %0d want 2", frame_id); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ack_swap_ready: got %b want 1", in_ready); end
        read(3, 5, r0, rd);
        checks++; if (r0 !== 16'hFC05) begin errors++; $display("FAIL f2_rd: got %h want fc05", r0); end
        checks++; if (rd !== 16'hFC05) begin errors++; $display("FAIL f2_rd_drop: got %h want fc05", rd); end
    endtask

    task automatic test_ack();
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ack_release: got %b want 0", frame_valid); end
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ack_idle_valid: got %b want 0", frame_valid); end
        checks++; if (frame_id !== 8'd2) begin errors++; $display("FAIL ack_idle_id: got %0d want 2", frame_id); end
    endtask

    task automatic test_sensor_mask();
        sensor_en = 8'h0F;
        do_reset();
        for (int z = 0; z < 64; z++) send_beat(6, z, 16'h6666);
        sensor_en = 8'hFF;
        for (int s = 0; s < 4; s++)
            for (int z = 0; z < 64; z++)
                if (!(s == 3 && z == 63)) send_beat(s, z, {8'(s), 8'(z)});
        end_beats();
        idle(3);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mask_early: got %b want 0", frame_valid); end
        send_beat(3, 63, 16'h033F);
        end_beats();
        idle(2);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL mask_valid: got %b want 1", frame_valid); end
        checks++; if (frame_id !== 8'd1) begin errors++; $display("FAIL mask_id: got %0d want 1", frame_id); end
        read(6, 9, r0, rd);
        checks++; if (r0 !== 16'h0609) begin errors++; $display("FAIL mask_s6: got %h want 0609", r0); end
        read(2, 7, r0, rd);
        checks++; if (r0 !== 16'h0207) begin errors++; $display("FAIL mask_s2: got %h want 0207", r0); end
    endtask

    task automatic test_overwrite();
        sensor_en = 8'hFF;
        do_reset();
        send_beat(0, 0, 16'h1111);
        send_beat(0, 0, 16'h2222);
        for (int s = 0; s < 8; s++)
            for (int z = 0; z < 64; z++)
                if (!(s == 0 && z == 0)) send_beat(s, z, {8'(s), 8'(z)});
        end_beats();
        idle(2);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovw_valid: got %b want 1", frame_valid); end
        idle(5);
        checks++; if (frame_id !== 8'd1) begin errors++; $display("FAIL ovw_one_frame: got %0d want 1", frame_id); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ovw_ready: got %b want 1", in_ready); end
        read(0, 0, r0, rd);
        checks++; if (r0 !== 16'h2222) begin errors++; $display("FAIL ovw_data: got %h want 2222", r0); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 300; i++) send_beat(i / 64, i % 64, 16'h5555);
        end_beats();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", frame_valid); end
        checks++; if (frame_id !== 8'd0) begin errors++; $display("FAIL mrst_id: got %0d want 0", frame_id); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 300; i < 512; i++) send_beat(i / 64, i % 64, {8'(i / 64), 8'(i % 64)});
        end_beats();
        idle(4);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL mrst_partial: got %b want 0", frame_valid); end
        send_frame(16'h0000);
        idle(2);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL mrst_fresh_valid: got %b want 1", frame_valid); end
        checks++; if (frame_id !== 8'd1) begin errors++; $display("FAIL mrst_fresh_id: got %0d want 1", frame_id); end
        read(5, 10, r0, rd);
        checks++; if (r0 !== 16'h050A) begin errors++; $display("FAIL mrst_rd: got %h want 050a", r0); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sensor = '0; in_zone = '0; in_data = '0;
        sensor_en = 8'hFF; frame_ack = 1'b0; rd_addr = '0;
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_ack();
        test_sensor_mask();
        test_overwrite();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
